// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Instruction fetch unit with a decoupled prefetch queue.
//               Issues sequential fetches over a request/response handshake
//               (at most one outstanding), buffers fetched {PC, instr} pairs
//               and feeds the F/D register. Supports decode stall and a
//               redirect that flushes all speculative work (no delay slot).
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 10,
    parameter int          QDEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    input  logic                     stall_D,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              Instr_D,
    output logic [31:0]              PC_D,
    output logic                     valid_D,
    output logic [31:0]              PC_F,
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int               c_PTR_W   = $clog2(QDEPTH);
    localparam int               c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_QDEPTH  = (c_CNT_W + 1)'(QDEPTH);

    // Architectural state
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_q_pc    [QDEPTH];
    logic [31:0]        r_q_instr [QDEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;
    logic               r_drop;
    logic [31:0]        r_instr_d;
    logic [31:0]        r_pc_d;
    logic               r_valid_d;

    // Per-cycle control decisions
    logic               w_redirect_eff;
    logic [c_CNT_W:0]   w_occupancy;
    logic               w_req;
    logic               w_accept;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;

    // Request guard, handshake and queue push/pop decisions for this cycle.
    // Occupancy counts the in-flight fetch so a response always has a slot;
    // a pop this cycle deliberately does not free a slot for the guard.
    always_comb begin
        w_redirect_eff = redirect && !stall_D;
        w_occupancy    = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
        w_req          = !RESET && !w_redirect_eff
                         && (!r_inflight || imem_rvalid)
                         && (w_occupancy < c_QDEPTH);
        w_accept       = w_req && imem_ready;
        w_resp         = imem_rvalid && r_inflight;
        w_push         = w_resp && !r_drop && !w_redirect_eff;
        w_pop          = !stall_D && !redirect && (r_count != '0);
    end

    // Queue storage: entries need no reset, validity is tracked by r_count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_inflight_pc;
            r_q_instr[r_tail] <= imem_rdata;
        end
    end

    // Fetch PC, outstanding-request tracking and queue pointers/occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_drop        <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            if (w_redirect_eff) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_accept) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else if (w_resp) begin
                r_inflight <= 1'b0;
            end

            // A response still owed for pre-redirect work must be swallowed.
            if (w_resp) begin
                r_drop <= 1'b0;
            end else if (w_redirect_eff && r_inflight) begin
                r_drop <= 1'b1;
            end

            if (w_redirect_eff) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    // F/D register: load the queue head, or insert a bubble when empty or
    // redirecting; hold while decode is stalled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_instr_d <= 32'd0;
            r_pc_d    <= 32'd0;
            r_valid_d <= 1'b0;
        end else if (!stall_D) begin
            if (w_pop) begin
                r_instr_d <= r_q_instr[r_head];
                r_pc_d    <= r_q_pc[r_head];
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= 32'd0;
                r_pc_d    <= 32'd0;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc[ADDR_W+1:2];
    assign Instr_D   = r_instr_d;
    assign PC_D      = r_pc_d;
    assign valid_D   = r_valid_d;
    assign PC_F      = r_fetch_pc;
    assign q_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Self-checking bench for ifu_prefetch. Queue-based reference
//               model compared every cycle, an instruction memory with
//               configurable latency/ready, and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

    localparam int QD = 4;
    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          stall_D;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   Instr_D;
    logic [31:0]   PC_D;
    logic          valid_D;
    logic [31:0]   PC_F;
    logic [2:0]    q_count;

    ifu_prefetch #(.RESET_PC(32'h0000_3000), .ADDR_W(AW), .QDEPTH(QD)) dut (
        .CLK(CLK), .RESET(RESET),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_D(stall_D), .redirect(redirect), .redirect_pc(redirect_pc),
        .Instr_D(Instr_D), .PC_D(PC_D), .valid_D(valid_D),
        .PC_F(PC_F), .q_count(q_count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] w);
        return 32'hC0DE_0000 | {22'd0, w};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory environment ----------------
    int          lat_mode   = 1;    // 0 = random 1..4, else fixed latency
    bit          ready_rand = 0;
    bit          ready_off  = 0;
    bit          stale_rv   = 0;
    bit          ready_bit  = 1;
    bit          mem_pend   = 0;
    int          mem_wait   = 0;
    logic [AW-1:0] mem_addr = '0;
    bit          s_acc = 0, s_rv = 0, s_rst = 0;
    logic [AW-1:0] s_addr = '0;

    assign imem_rvalid = (mem_pend && mem_wait == 0) || stale_rv;
    assign imem_ready  = ready_bit && !ready_off;
    assign imem_rdata  = stale_rv ? 32'hBAD0_BAD0 : mem_word(mem_addr);

    initial begin
        forever begin
            @(posedge CLK); #1;
            if (s_rst) begin
                mem_pend = 0;
            end else begin
                if (s_rv) mem_pend = 0;
                else if (mem_pend && mem_wait != 0) mem_wait--;
                if (s_acc) begin
                    mem_pend = 1;
                    mem_addr = s_addr;
                    mem_wait = (lat_mode == 0) ? int'($urandom_range(3, 0)) : lat_mode - 1;
                end
            end
            ready_bit = ready_rand ? bit'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = 32'd0, m_ipc = 32'd0, m_pcd = 32'd0, m_insd = 32'd0;
    bit          m_infl = 0, m_drop = 0, m_vd = 0, m_init = 0;

    // Compare DUT against the model, then advance the model by one edge.
    initial begin
        bit   m_reff, m_req, m_resp, m_acc;
        ent_t e;
        forever begin
            @(negedge CLK);
            m_reff = redirect && !stall_D;
            m_req  = !RESET && !m_reff && (!m_infl || imem_rvalid)
                     && ((mq.size() + int'(m_infl)) < QD);
            if (m_init) begin
                chk("PC_D", PC_D, m_pcd);
                chk("Instr_D", Instr_D, m_insd);
                chk("valid_D", 32'(valid_D), 32'(m_vd));
                chk("PC_F", PC_F, m_pc);
                chk("q_count", 32'(q_count), 32'(mq.size()));
                chk("imem_req", 32'(imem_req), 32'(m_req));
                if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
                if (valid_D) chk("Instr_vs_mem", Instr_D, mem_word(PC_D[AW+1:2]));
            end
            s_acc  = imem_req && imem_ready;
            s_rv   = imem_rvalid;
            s_addr = imem_addr;
            s_rst  = RESET;

            m_resp = imem_rvalid && m_infl;
            m_acc  = m_req && imem_ready;
            if (RESET) begin
                mq.delete();
                m_pc = 32'h3000; m_ipc = 32'd0; m_infl = 0; m_drop = 0;
                m_pcd = 32'd0; m_insd = 32'd0; m_vd = 0; m_init = 1;
            end else begin
                if (!stall_D) begin
                    if (redirect || mq.size() == 0) begin
                        m_vd = 0; m_pcd = 32'd0; m_insd = 32'd0;
                    end else begin
                        e = mq.pop_front();
                        m_vd = 1; m_pcd = e.pc; m_insd = e.ins;
                    end
                end
                if (m_reff) mq.delete();
                if (m_resp) begin
                    if (m_drop) m_drop = 0;
                    else if (!m_reff) mq.push_back(ent_t'({m_ipc, imem_rdata}));
                end else if (m_reff && m_infl) begin
                    m_drop = 1;
                end
                if (m_acc) begin
                    m_infl = 1; m_ipc = m_pc;
                end else if (m_resp) begin
                    m_infl = 0;
                end
                if (m_reff) m_pc = {redirect_pc[31:2], 2'b00};
                else if (m_acc) m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        int n = 0;
        while (valid_D !== 1'b1 && n < maxc) begin
            step(1);
            n++;
        end
        if (valid_D !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: valid_D still %b after %0d cycles, expected 1", nm, valid_D, maxc);
        end
    endtask

    task automatic wait_infl(input int maxc, input string nm);
        int n  = 0;
        bit ok = 0;
        while (!ok && n < maxc) begin
            step(1); #1;
            ok = m_infl && !imem_rvalid;
            n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: no pending fetch after %0d cycles, expected one", nm, maxc);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RESET = 1; stall_D = 0; redirect = 0; redirect_pc = 32'd0;
        repeat (3) @(posedge CLK);
        chk("req_in_reset", 32'(imem_req), 32'd0);
        #1; RESET = 0; #1;
        chk("rst_valid_D", 32'(valid_D), 32'd0);
        chk("rst_PC_D", PC_D, 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_PC_F", PC_F, 32'h3000);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'd0);

        // Zero-wait stream: D sees 0x3000 after edge 3
        step(3);
        chk("seq0_PC", PC_D, 32'h3000);
        chk("seq0_valid", 32'(valid_D), 32'd1);
        chk("seq0_instr", Instr_D, 32'hC0DE_0000);
        step(1); chk("seq1_PC", PC_D, 32'h3004);
        step(1); chk("seq2_PC", PC_D, 32'h3008);

        // Stall for 10 cycles: queue fills, fetch stops, D holds
        stall_D = 1;
        step(10);
        chk("stall_q_full", 32'(q_count), 32'd4);
        chk("stall_no_req", 32'(imem_req), 32'd0);
        chk("stall_hold_PC", PC_D, 32'h3008);
        chk("stall_PC_F", PC_F, 32'h301C);

        // Redirect under stall is ignored
        redirect = 1; redirect_pc = 32'h3200;
        step(1);
        chk("stallredir_PC_F", PC_F, 32'h301C);
        chk("stallredir_q", 32'(q_count), 32'd4);
        chk("stallredir_PC_D", PC_D, 32'h3008);

        // Same redirect unstalled takes effect
        stall_D = 0;
        step(1);
        redirect = 0;
        chk("redir_valid", 32'(valid_D), 32'd0);
        chk("redir_q", 32'(q_count), 32'd0);
        chk("redir_PC_F", PC_F, 32'h3200);
        step(1); chk("bubble1", 32'(valid_D), 32'd0);
        step(1); chk("bubble2", 32'(valid_D), 32'd0);
        step(1);
        chk("redir_tgt_PC", PC_D, 32'h3200);
        chk("redir_tgt_valid", 32'(valid_D), 32'd1);
        chk("redir_tgt_instr", Instr_D, 32'hC0DE_0080);

        // Stall then release: no gap, no duplicate
        stall_D = 1;
        step(10);
        chk("stall2_hold", PC_D, 32'h3200);
        chk("stall2_q", 32'(q_count), 32'd4);
        stall_D = 0;
        step(1); chk("release0", PC_D, 32'h3204);
        step(1); chk("release1", PC_D, 32'h3208);

        // Redirect while a slow fetch is in flight: stale response dropped
        lat_mode = 3;
        wait_infl(20, "slow_pending");
        redirect = 1; redirect_pc = 32'h3103;
        step(1);
        redirect = 0;
        chk("drop_valid", 32'(valid_D), 32'd0);
        chk("drop_q", 32'(q_count), 32'd0);
        chk("drop_PC_F", PC_F, 32'h3100);
        wait_valid(40, "drop_target");
        chk("drop_tgt_PC", PC_D, 32'h3100);
        chk("drop_tgt_instr", Instr_D, 32'hC0DE_0040);

        // Random latency/ready with random stalls and redirects
        lat_mode = 0; ready_rand = 1;
        for (int i = 0; i < 400; i++) begin
            stall_D     = ($urandom_range(3, 0) == 0);
            redirect    = ($urandom_range(15, 0) == 0);
            redirect_pc = 32'h3000 + ($urandom_range(255, 0) << 2) + $urandom_range(3, 0);
            step(1);
        end
        stall_D = 0; redirect = 0; ready_rand = 0;

        // Reset mid-stream with a response pending; stale rvalid ignored
        lat_mode = 4;
        wait_infl(20, "reset_pending");
        RESET = 1; ready_off = 1; stale_rv = 1;
        step(1);
        chk("mrst_valid", 32'(valid_D), 32'd0);
        chk("mrst_PC_D", PC_D, 32'd0);
        chk("mrst_instr", Instr_D, 32'd0);
        chk("mrst_q", 32'(q_count), 32'd0);
        chk("mrst_PC_F", PC_F, 32'h3000);
        RESET = 0;
        step(1);
        chk("stale_q", 32'(q_count), 32'd0);
        chk("stale_PC_F", PC_F, 32'h3000);
        chk("stale_valid", 32'(valid_D), 32'd0);
        ready_off = 0; stale_rv = 0; lat_mode = 1;
        wait_valid(20, "after_reset");
        chk("mrst_first_PC", PC_D, 32'h3000);
        chk("mrst_first_instr", Instr_D, 32'hC0DE_0000);
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
